// File: rtl/bldc_commutation_ctrl.sv
// Six-step trapezoidal commutation sequencer for a BLDC drive.
//
// Hall inputs pass through a 2-flop synchronizer and a stability filter, are
// decoded to a sector, and drive the three half-bridge enables from a fixed
// six-step table. Every sector or direction change goes through DEAD_CYC
// all-off cycles before the new pattern is applied. The duty value handed to
// the PWM generator is slewed one LSB every RAMP_DIV clocks toward the target.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   enable       run request
//   dir          0 = forward, 1 = reverse
//   hall[2:0]    raw Hall inputs {C,B,A}, asynchronous
//   duty_target  requested duty
//   duty_sel     ramped duty to the PWM `sel` input
//   high_en[2:0] high-side enables, bit0 = A, bit1 = B, bit2 = C
//   low_en[2:0]  low-side enables, same bit order
//   fault        invalid Hall code latched
//   sector[2:0]  last decoded sector 0..5
module bldc_commutation_ctrl #(
  parameter int DEAD_CYC  = 16,
  parameter int HALL_FILT = 4,
  parameter int RAMP_DIV  = 256
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic       dir,
  input  logic [2:0] hall,
  input  logic [7:0] duty_target,
  output logic [7:0] duty_sel,
  output logic [2:0] high_en,
  output logic [2:0] low_en,
  output logic       fault,
  output logic [2:0] sector
);

  localparam int FW = $clog2(HALL_FILT + 1);
  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DEAD, FAULT} state_t;

  // ---------------------------------------------------------------------------
  // Hall synchronizer and stability filter
  // ---------------------------------------------------------------------------
  logic [2:0]    hall_meta, hall_sync, hall_prev, hall_filt;
  logic [FW-1:0] stable_cnt, run_len;

  // run_len = number of consecutive cycles hall_sync has held its value,
  // including the current one, saturating at HALL_FILT.
  always_comb begin
    if (hall_sync != hall_prev)            run_len = FW'(1);
    else if (stable_cnt == FW'(HALL_FILT)) run_len = stable_cnt;
    else                                   run_len = stable_cnt + FW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hall_meta  <= '0;
      hall_sync  <= '0;
      hall_prev  <= '0;
      hall_filt  <= '0;
      stable_cnt <= '0;
    end else begin
      hall_meta  <= hall;
      hall_sync  <= hall_meta;
      hall_prev  <= hall_sync;
      stable_cnt <= run_len;
      if (run_len == FW'(HALL_FILT)) hall_filt <= hall_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // Sector decode
  // ---------------------------------------------------------------------------
  logic       hall_valid;
  logic [2:0] hall_sec;

  always_comb begin
    hall_valid = 1'b1;
    hall_sec   = 3'd0;
    case (hall_filt)
      3'b101:  hall_sec = 3'd0;
      3'b100:  hall_sec = 3'd1;
      3'b110:  hall_sec = 3'd2;
      3'b010:  hall_sec = 3'd3;
      3'b011:  hall_sec = 3'd4;
      3'b001:  hall_sec = 3'd5;
      default: hall_valid = 1'b0;
    endcase
  end

  // {high, low} for a sector; reverse drives the same pair with roles swapped.
  function automatic logic [5:0] drive_pat(input logic [2:0] sec, input logic rev);
    logic [2:0] hi, lo;
    case (sec)
      3'd0:    begin hi = 3'b001; lo = 3'b010; end
      3'd1:    begin hi = 3'b001; lo = 3'b100; end
      3'd2:    begin hi = 3'b010; lo = 3'b100; end
      3'd3:    begin hi = 3'b010; lo = 3'b001; end
      3'd4:    begin hi = 3'b100; lo = 3'b001; end
      3'd5:    begin hi = 3'b100; lo = 3'b010; end
      default: begin hi = 3'b000; lo = 3'b000; end
    endcase
    return rev ? {lo, hi} : {hi, lo};
  endfunction

  // ---------------------------------------------------------------------------
  // Duty ramp step
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre;
  logic          ramp_tick;
  logic [7:0]    duty_next;

  always_comb begin
    ramp_tick = (pre == PW'(RAMP_DIV - 1));
    duty_next = duty_sel;
    if (ramp_tick) begin
      if (duty_sel < duty_target)      duty_next = duty_sel + 8'd1;
      else if (duty_sel > duty_target) duty_next = duty_sel - 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Commutation FSM
  // ---------------------------------------------------------------------------
  state_t        state;
  logic [2:0]    drv_sec;   // sector/dir currently applied to the bridge
  logic          drv_dir;
  logic [DW-1:0] dead_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      duty_sel <= '0;
      high_en  <= '0;
      low_en   <= '0;
      fault    <= 1'b0;
      sector   <= '0;
      pre      <= '0;
      drv_sec  <= '0;
      drv_dir  <= 1'b0;
      dead_cnt <= '0;
    end else begin
      if (hall_valid) sector <= hall_sec;

      case (state)
        IDLE: begin
          high_en  <= '0;
          low_en   <= '0;
          duty_sel <= '0;
          pre      <= '0;
          fault    <= 1'b0;
          if (enable) begin
            if (hall_valid) begin
              state              <= RUN;
              drv_sec            <= hall_sec;
              drv_dir            <= dir;
              {high_en, low_en}  <= drive_pat(hall_sec, dir);
            end else begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end
        end

        RUN, DEAD: begin
          if (!enable) begin
            state    <= IDLE;
            high_en  <= '0;
            low_en   <= '0;
            duty_sel <= '0;
            pre      <= '0;
          end else if (!hall_valid) begin
            state    <= FAULT;
            fault    <= 1'b1;
            high_en  <= '0;
            low_en   <= '0;
            duty_sel <= '0;
            pre      <= '0;
          end else begin
            pre      <= ramp_tick ? '0 : pre + PW'(1);
            duty_sel <= duty_next;
            if (state == RUN) begin
              if (hall_sec != drv_sec || dir != drv_dir) begin
                state    <= DEAD;
                dead_cnt <= DW'(DEAD_CYC - 1);
                high_en  <= '0;
                low_en   <= '0;
              end
            end else if (dead_cnt == '0) begin
              // Whatever sector/dir is current at exit gets driven; changes
              // seen during the dead window do not restart it.
              state             <= RUN;
              drv_sec           <= hall_sec;
              drv_dir           <= dir;
              {high_en, low_en} <= drive_pat(hall_sec, dir);
            end else begin
              dead_cnt <= dead_cnt - DW'(1);
            end
          end
        end

        FAULT: begin
          high_en  <= '0;
          low_en   <= '0;
          duty_sel <= '0;
          pre      <= '0;
          fault    <= 1'b1;
          if (!enable) begin
            state <= IDLE;
            fault <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Bench for bldc_commutation_ctrl: directed steps from the test plan followed
// by a randomized Hall/enable/dir/duty sequence, all checked cycle by cycle
// against a behavioural model of the commutation rules.
module tb_bldc_commutation_ctrl;
  localparam int DEAD_CYC  = 16;
  localparam int HALL_FILT = 4;
  localparam int RAMP_DIV  = 4;

  localparam int M_IDLE = 0, M_RUN = 1, M_DEAD = 2, M_FAULT = 3;

  logic       CLK = 1'b0;
  logic       RST, enable, dir;
  logic [2:0] hall;
  logic [7:0] duty_target;
  logic [7:0] duty_sel;
  logic [2:0] high_en, low_en, sector;
  logic       fault;

  int checks = 0;
  int errors = 0;

  bldc_commutation_ctrl #(
    .DEAD_CYC (DEAD_CYC),
    .HALL_FILT(HALL_FILT),
    .RAMP_DIV (RAMP_DIV)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (enable),
    .dir        (dir),
    .hall       (hall),
    .duty_target(duty_target),
    .duty_sel   (duty_sel),
    .high_en    (high_en),
    .low_en     (low_en),
    .fault      (fault),
    .sector     (sector)
  );

  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int code2sec [8] = '{-1, 5, 3, 4, 1, 0, 2, -1};  // index = Hall code
  int sec2code [6] = '{5, 4, 6, 2, 3, 1};

  int pin_q[$];      // two-stage pin delay
  int sync_hist[$];  // last HALL_FILT synchronized samples
  int m_filt, m_mode, m_sec_out, m_cur_sec, m_cur_dir, m_dead_left;
  int m_tick, m_duty, m_hi, m_lo, m_fault;

  task automatic model_reset();
    pin_q.delete();
    pin_q.push_back(0);
    pin_q.push_back(0);
    sync_hist.delete();
    m_filt = 0; m_mode = M_IDLE; m_sec_out = 0; m_cur_sec = 0; m_cur_dir = 0;
    m_dead_left = 0; m_tick = 0; m_duty = 0; m_hi = 0; m_lo = 0; m_fault = 0;
  endtask

  // Phase index A=0,B=1,C=2: forward high phase is sector/2, low phase is the
  // one after the high phase of the following half-step.
  task automatic set_drive(int s, int d);
    int h, l, t;
    h = s / 2;
    l = ((s + 1) / 2 + 1) % 3;
    if (d != 0) begin t = h; h = l; l = t; end
    m_hi = 1 << h;
    m_lo = 1 << l;
  endtask

  task automatic model_edge();
    int fs, hs;
    bit same;
    if (RST) begin
      model_reset();
      return;
    end
    fs = code2sec[m_filt];
    if (fs >= 0) m_sec_out = fs;

    case (m_mode)
      M_IDLE: begin
        m_hi = 0; m_lo = 0; m_duty = 0; m_tick = 0; m_fault = 0;
        if (enable) begin
          if (fs >= 0) begin
            m_mode = M_RUN; m_cur_sec = fs; m_cur_dir = int'(dir);
            set_drive(fs, int'(dir));
          end else begin
            m_mode = M_FAULT; m_fault = 1;
          end
        end
      end
      M_RUN, M_DEAD: begin
        if (!enable) begin
          m_mode = M_IDLE; m_hi = 0; m_lo = 0; m_duty = 0; m_tick = 0;
        end else if (fs < 0) begin
          m_mode = M_FAULT; m_fault = 1; m_hi = 0; m_lo = 0; m_duty = 0; m_tick = 0;
        end else begin
          m_tick++;
          if (m_tick == RAMP_DIV) begin
            m_tick = 0;
            if (m_duty < int'(duty_target)) m_duty++;
            else if (m_duty > int'(duty_target)) m_duty--;
          end
          if (m_mode == M_RUN) begin
            if (fs != m_cur_sec || int'(dir) != m_cur_dir) begin
              m_mode = M_DEAD; m_dead_left = DEAD_CYC; m_hi = 0; m_lo = 0;
            end
          end else begin
            m_dead_left--;
            if (m_dead_left == 0) begin
              m_mode = M_RUN; m_cur_sec = fs; m_cur_dir = int'(dir);
              set_drive(fs, int'(dir));
            end
          end
        end
      end
      default: begin
        m_hi = 0; m_lo = 0; m_duty = 0; m_tick = 0; m_fault = 1;
        if (!enable) begin m_mode = M_IDLE; m_fault = 0; end
      end
    endcase

    hs = pin_q.pop_front();
    pin_q.push_back(int'(hall));
    sync_hist.push_back(hs);
    if (sync_hist.size() > HALL_FILT) void'(sync_hist.pop_front());
    same = (sync_hist.size() == HALL_FILT);
    foreach (sync_hist[i]) if (sync_hist[i] != hs) same = 0;
    if (same) m_filt = hs;
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("high_en",    8'(high_en), 8'(m_hi));
    chk("low_en",     8'(low_en),  8'(m_lo));
    chk("fault",      8'(fault),   8'(m_fault));
    chk("sector",     8'(sector),  8'(m_sec_out));
    chk("duty_sel",   duty_sel,    8'(m_duty));
    chk("no_overlap", 8'(high_en & low_en), 8'd0);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n_off, cur, r, code, hold;
    bit seen;

    model_reset();
    RST = 1'b1; enable = 1'b0; dir = 1'b0; hall = 3'b101; duty_target = 8'd0;

    // Reset / idle
    repeat (3) tick();
    chk("rst_high", 8'(high_en), 8'd0);
    chk("rst_low",  8'(low_en),  8'd0);
    chk("rst_fault", 8'(fault),  8'd0);
    chk("rst_duty", duty_sel,    8'd0);
    RST = 1'b0;
    repeat (8) tick();

    // Start and ramp up to 10
    enable = 1'b1; duty_target = 8'd10;
    tick();
    chk("start_high", 8'(high_en), 8'b001);
    chk("start_low",  8'(low_en),  8'b010);
    repeat (39) tick();
    chk("ramp_39", duty_sel, 8'd9);
    tick();
    chk("ramp_40", duty_sel, 8'd10);
    repeat (8) tick();
    chk("ramp_hold", duty_sel, 8'd10);

    // Commutation s0 -> s1 with dead time
    hall = 3'b100;
    n_off = 0; seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (high_en == 3'b000 && low_en == 3'b000) n_off++;
      else if (high_en == 3'b001 && low_en == 3'b100) begin seen = 1; break; end
    end
    chk("dead_len",    8'(n_off), 8'(DEAD_CYC));
    chk("comm_seen",   8'(seen),  8'd1);
    chk("comm_sector", 8'(sector), 8'd1);

    // Move to s2, then reverse
    hall = 3'b110;
    repeat (40) tick();
    chk("s2_high", 8'(high_en), 8'b010);
    chk("s2_low",  8'(low_en),  8'b100);
    dir = 1'b1;
    tick();
    chk("dir_first_high", 8'(high_en), 8'd0);
    chk("dir_first_low",  8'(low_en),  8'd0);
    repeat (15) tick();
    chk("dir_last_dead", 8'(high_en | low_en), 8'd0);
    tick();
    chk("rev_high", 8'(high_en), 8'b100);
    chk("rev_low",  8'(low_en),  8'b010);

    // 2-cycle glitch is filtered out
    hall = 3'b011; tick(); tick();
    hall = 3'b110;
    repeat (12) tick();
    chk("glitch_sector", 8'(sector),  8'd2);
    chk("glitch_high",   8'(high_en), 8'b100);

    // Invalid code latches fault; enable low clears it
    hall = 3'b111;
    repeat (8) tick();
    chk("inv_fault", 8'(fault), 8'd1);
    chk("inv_off",   8'(high_en | low_en), 8'd0);
    chk("inv_duty",  duty_sel, 8'd0);
    enable = 1'b0;
    tick();
    chk("fault_clear", 8'(fault), 8'd0);
    hall = 3'b101;
    repeat (8) tick();

    // Ramp to 200, then down toward 50
    dir = 1'b0; enable = 1'b1; duty_target = 8'd200;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (duty_sel == 8'd200) break;
    end
    chk("ramp_200", duty_sel, 8'd200);
    duty_target = 8'd50;
    repeat (4) tick();
    chk("down_1", duty_sel, 8'd199);
    repeat (4) tick();
    chk("down_2", duty_sel, 8'd198);

    // Abort in the middle of a dead window
    hall = 3'b100;
    repeat (10) tick();
    chk("mid_dead", 8'(high_en | low_en), 8'd0);
    enable = 1'b0;
    tick();
    chk("abort_duty", duty_sel, 8'd0);
    chk("abort_off",  8'(high_en | low_en), 8'd0);

    // Reset while running
    enable = 1'b1;
    repeat (10) tick();
    RST = 1'b1;
    tick();
    chk("rst_run_off",    8'(high_en | low_en), 8'd0);
    chk("rst_run_sector", 8'(sector), 8'd0);
    RST = 1'b0;

    // Randomized operation
    cur = 1;
    for (int seg = 0; seg < 150; seg++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) begin
        cur = (dir == 1'b0) ? (cur + 1) % 6 : (cur + 5) % 6;
        code = sec2code[cur];
      end else if (r < 75) begin
        code = ($urandom_range(0, 1) == 0) ? 0 : 7;
      end else begin
        cur = int'($urandom_range(0, 5));
        code = sec2code[cur];
      end
      hall   = 3'(code);
      hold   = int'($urandom_range(1, 30));
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 3) == 0) duty_target = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 59) == 0) begin
        RST = 1'b1; tick(); tick(); RST = 1'b0;
      end
      repeat (hold) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
